alu_flags_stage: RTL and testbench
==================================

Name: alu_flags_stage

Overview:
Execute stage directly downstream of the shifter. It consumes the shifter's OPERAND and shifter carry-out and combines them with the Rn value under the data-processing fields of IR. It evaluates the ARM condition code, computes the result, and holds the CPSR NZCV flags register. The stored C flag feeds back to the shifter CIN input. The stage is multi-cycle with a START/DONE handshake under control-unit sequencing.

Parameters:
FLAGS_RST, 4'b0000, NZCV value loaded on reset.

Ports:
CLK  input  1  rising-edge clock
RESET  input  1  asynchronous, active-high reset
START  input  1  request; sampled only in IDLE
IR  input  32  instruction; uses [31:28] cond, [24:21] opcode, [20] S
RN  input  32  first operand from register file
OPERAND  input  32  second operand from shifter
SHIFT_COUT  input  1  shifter carry-out
RESULT  output  32  registered ALU result
FLAGS  output  4  NZCV register, bit3=N, bit0=V
CIN_OUT  output  1  FLAGS[1] (C), wired to shifter CIN
WRITE_RD  output  1  result must be written to Rd; valid while DONE=1
BUSY  output  1  high in LATCH and EXEC
DONE  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, any state): state=IDLE, RESULT=0, FLAGS=FLAGS_RST, WRITE_RD=0, BUSY=0, DONE=0. An operation in flight is discarded and flags are not updated.
- FSM states are IDLE, LATCH, EXEC, DONE_ST.
  - IDLE: on START=1, move to LATCH.
  - LATCH: register IR, RN, OPERAND and SHIFT_COUT into internal regs. Move to EXEC.
  - EXEC: evaluate the condition against the current FLAGS, compute, register RESULT/WRITE_RD/new FLAGS. Move to DONE_ST.
  - DONE_ST: DONE=1 for exactly one cycle. Move to IDLE.
- Latency: START at edge k gives DONE high in cycle k+3. START outside IDLE is ignored; there is no queueing.
- Condition codes: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL. Code 1111 is treated as never.
  - On failure: RESULT holds its previous value, FLAGS unchanged, WRITE_RD=0, DONE still pulses.
- Opcodes: AND, EOR, SUB, RSB, ADD, ADC, SBC, RSC, TST, TEQ, CMP, CMN, ORR, MOV, BIC, MVN, with standard ARM semantics.
  - ADC, SBC and RSC use the latched C flag.
  - Arithmetic is done in a 33-bit sum. Subtraction is A + ~B + 1 (or + C for SBC/RSC), so C = NOT borrow.
- Flag update occurs when S=1, or always for TST/TEQ/CMP/CMN.
  - N = RESULT[31]; Z = (RESULT==0).
  - Logical ops: C = latched SHIFT_COUT, V unchanged.
  - Arithmetic ops: C = bit 32 of the sum; V = signed overflow, i.e. operand signs equal and result sign differs (after operand inversion for subtraction).
- WRITE_RD=0 for TST/TEQ/CMP/CMN; RESULT is still computed internally but not driven to RESULT.
- CIN_OUT always reflects the current FLAGS[1]. Flags update at the EXEC edge only, so the shifter sees the new C in the next instruction.

Optional Feature:
ALU_COND_EVAL_EN
- Defined: condition evaluation is as above.
- Undefined: IR[31:28] is ignored and every instruction executes as AL. FLAGS still update per the S rules. The condition logic is removed.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_AND through OP_MVN
  - condition localparams COND_EQ through COND_NV
  - state encoding
  - FLAG_N/Z/C/V bit indices
- One sub-module, cond_check (combinational: cond[3:0], flags[3:0] to pass). It is reused later by the branch unit.

Test Plan:
1. ADDS overflow: reset, IR=0xE09A102C (AL ADDS), RN=0x7FFFFFFF, OPERAND=0x00000001, START pulse -> DONE at cycle +3, RESULT=0x80000000, FLAGS=4'b1001, WRITE_RD=1.
2. CMP equal: IR cond=AL, opcode=CMP, RN=5, OPERAND=5 -> FLAGS=4'b0110, WRITE_RD=0, RESULT unchanged from the previous value.
3. Condition fail: FLAGS=4'b0000, IR cond=EQ ADDS, RN=1, OPERAND=1 -> DONE pulses, WRITE_RD=0, FLAGS stay 4'b0000.
   - Repeat with ALU_COND_EVAL_EN undefined -> RESULT=2, WRITE_RD=1.
4. MOVS logical carry: V preset to 1, OPERAND=0, SHIFT_COUT=1 -> RESULT=0, FLAGS=4'b0111, CIN_OUT=1 from the next cycle.
5. ADC/SBC chain: C=1, ADC with RN=0xFFFFFFFF, OPERAND=0 -> RESULT=0, C=1. Then SBCS with RN=3, OPERAND=1 -> RESULT=2, C=1.
6. Reset mid-operation and START while BUSY:
   - Assert RESET in EXEC -> all outputs at reset values immediately, no DONE.
   - START held high during LATCH/EXEC -> exactly one DONE per accepted start.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU/flags execute stage: opcodes, condition codes,
// FSM states, NZCV bit positions and the latched request record.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
                         OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
                         OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
                         OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
                         COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
                         COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
                         COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_EXEC, S_DONE} state_e;

  typedef struct packed {
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        s;
    logic [31:0] rn;
    logic [31:0] b;
    logic        sc;
  } alu_req_t;

  // TST/TEQ/CMP/CMN: always set flags, never write Rd
  function automatic logic is_test_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_flags_stage_if.sv
// Control-unit/shifter facing bus of the ALU/flags stage.
interface alu_flags_stage_if;
  logic        START;
  logic [31:0] IR;
  logic [31:0] RN;
  logic [31:0] OPERAND;
  logic        SHIFT_COUT;
  logic [31:0] RESULT;
  logic [3:0]  FLAGS;
  logic        CIN_OUT;
  logic        WRITE_RD;
  logic        BUSY;
  logic        DONE;

  modport master (output START, IR, RN, OPERAND, SHIFT_COUT,
                  input  RESULT, FLAGS, CIN_OUT, WRITE_RD, BUSY, DONE);
  modport slave  (input  START, IR, RN, OPERAND, SHIFT_COUT,
                  output RESULT, FLAGS, CIN_OUT, WRITE_RD, BUSY, DONE);
endinterface

// File: rtl/alu_flags_stage_cond_check.sv
// ARM condition-code evaluator; purely combinational so the branch unit can reuse it.
module cond_check
  import alu_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags_i;

  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_flags_stage.sv
// Multi-cycle ALU execute stage holding the NZCV register (C feeds the shifter).
// ALU_COND_EVAL_EN: when defined, IR[31:28] gates execution; otherwise all ops run as AL.
module alu_flags_stage
  import alu_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic               CLK,
  input  logic               RESET,
  alu_flags_stage_if.slave   bus
);
  state_e      state_q, state_d;
  alu_req_t    req_q;
  logic [31:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  logic        wr_q, wr_d;

  logic [31:0] x, y, logic_r, alu_res;
  logic        cin, arith, pass, test;
  logic [32:0] sum;
  logic [3:0]  new_flags;

  logic unused_ir;
  assign unused_ir = ^{bus.IR[27:25], bus.IR[19:0]};

`ifdef ALU_COND_EVAL_EN
  cond_check u_cond (.cond_i(req_q.cond), .flags_i(flags_q), .pass_o(pass));
`else
  logic unused_cond;
  assign unused_cond = ^req_q.cond;
  assign pass = 1'b1;
`endif

  assign test = is_test_op(req_q.opcode);

  // Subtractions feed the inverted operand through the same 33-bit adder
  always_comb begin
    x       = req_q.rn;
    y       = req_q.b;
    cin     = 1'b0;
    arith   = 1'b1;
    logic_r = '0;
    case (req_q.opcode)
      OP_SUB, OP_CMP: begin y = ~req_q.b; cin = 1'b1; end
      OP_RSB:         begin x = req_q.b; y = ~req_q.rn; cin = 1'b1; end
      OP_ADD, OP_CMN: ;
      OP_ADC:         cin = flags_q[FLAG_C];
      OP_SBC:         begin y = ~req_q.b; cin = flags_q[FLAG_C]; end
      OP_RSC:         begin x = req_q.b; y = ~req_q.rn; cin = flags_q[FLAG_C]; end
      OP_AND, OP_TST: begin arith = 1'b0; logic_r = req_q.rn & req_q.b; end
      OP_EOR, OP_TEQ: begin arith = 1'b0; logic_r = req_q.rn ^ req_q.b; end
      OP_ORR:         begin arith = 1'b0; logic_r = req_q.rn | req_q.b; end
      OP_MOV:         begin arith = 1'b0; logic_r = req_q.b; end
      OP_BIC:         begin arith = 1'b0; logic_r = req_q.rn & ~req_q.b; end
      default:        begin arith = 1'b0; logic_r = ~req_q.b; end
    endcase
    sum     = {1'b0, x} + {1'b0, y} + {32'b0, cin};
    alu_res = arith ? sum[31:0] : logic_r;
    new_flags[FLAG_N] = alu_res[31];
    new_flags[FLAG_Z] = (alu_res == '0);
    new_flags[FLAG_C] = arith ? sum[32] : req_q.sc;
    new_flags[FLAG_V] = arith ? ((x[31] == y[31]) && (sum[31] != x[31])) : flags_q[FLAG_V];
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    wr_d     = wr_q;
    case (state_q)
      S_IDLE:  if (bus.START) state_d = S_LATCH;
      S_LATCH: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_DONE;
        wr_d    = pass && !test;
        if (pass && !test)              result_d = alu_res;
        if (pass && (req_q.s || test))  flags_d  = new_flags;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      req_q    <= '0;
      result_q <= '0;
      flags_q  <= FLAGS_RST;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      wr_q     <= wr_d;
      if (state_q == S_LATCH)
        req_q <= '{cond: bus.IR[31:28], opcode: bus.IR[24:21], s: bus.IR[20],
                   rn: bus.RN, b: bus.OPERAND, sc: bus.SHIFT_COUT};
    end
  end

  assign bus.RESULT   = result_q;
  assign bus.FLAGS    = flags_q;
  assign bus.CIN_OUT  = flags_q[FLAG_C];
  assign bus.WRITE_RD = wr_q;
  assign bus.BUSY     = (state_q == S_LATCH) || (state_q == S_EXEC);
  assign bus.DONE     = (state_q == S_DONE);
endmodule

// File: tb/tb_alu_flags_stage.sv
// Self-checking bench for alu_flags_stage: directed scenarios plus randomized ops vs an arithmetic model.
module tb_alu_flags_stage;
  logic CLK = 1'b0;
  logic RESET;
  int checks = 0;
  int failures = 0;

  alu_flags_stage_if bus ();
  alu_flags_stage #(.FLAGS_RST(4'b0000)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mk_ir(input logic [3:0] cond, input logic [3:0] opc, input logic s);
    return {cond, 3'b000, opc, s, 20'h00000};
  endfunction

  // Reference: flags/result evolve by plain integer arithmetic on the spec rules
  function automatic void model(input logic [31:0] ir, input logic [31:0] rn, input logic [31:0] b,
                                input logic sc, inout logic [3:0] f, inout logic [31:0] r,
                                output logic wr);
    logic [3:0] opc;
    logic n, z, c, v, pass, arith, is_add, testop;
    longint ua, ub, sa, sb, ur, sr, ci;
    logic [31:0] val;
    opc = ir[24:21];
    {n, z, c, v} = f;
    ci = c ? 64'sd1 : 64'sd0;
    ua = longint'(rn); ub = longint'(b);
    sa = longint'($signed(rn)); sb = longint'($signed(b));
    arith = 1'b1; is_add = 1'b0; ur = 0; sr = 0; val = '0;
    case (opc)
      4'h0, 4'h8: begin arith = 1'b0; val = rn & b; end
      4'h1, 4'h9: begin arith = 1'b0; val = rn ^ b; end
      4'hC:       begin arith = 1'b0; val = rn | b; end
      4'hD:       begin arith = 1'b0; val = b; end
      4'hE:       begin arith = 1'b0; val = rn & ~b; end
      4'hF:       begin arith = 1'b0; val = ~b; end
      4'h2, 4'hA: begin ur = ua - ub; sr = sa - sb; end
      4'h3:       begin ur = ub - ua; sr = sb - sa; end
      4'h4, 4'hB: begin ur = ua + ub; sr = sa + sb; is_add = 1'b1; end
      4'h5:       begin ur = ua + ub + ci; sr = sa + sb + ci; is_add = 1'b1; end
      4'h6:       begin ur = ua - ub - (1 - ci); sr = sa - sb - (1 - ci); end
      default:    begin ur = ub - ua - (1 - ci); sr = sb - sa - (1 - ci); end
    endcase
    if (arith) val = ur[31:0];
`ifdef ALU_COND_EVAL_EN
    case (ir[31:28])
      4'h0: pass = z;            4'h1: pass = !z;
      4'h2: pass = c;            4'h3: pass = !c;
      4'h4: pass = n;            4'h5: pass = !n;
      4'h6: pass = v;            4'h7: pass = !v;
      4'h8: pass = c && !z;      4'h9: pass = !c || z;
      4'hA: pass = n == v;       4'hB: pass = n != v;
      4'hC: pass = !z && n == v; 4'hD: pass = z || n != v;
      4'hE: pass = 1'b1;         default: pass = 1'b0;
    endcase
`else
    pass = 1'b1;
`endif
    testop = (opc >= 4'h8) && (opc <= 4'hB);
    wr = pass && !testop;
    if (pass && !testop) r = val;
    if (pass && (ir[20] || testop)) begin
      n = val[31];
      z = (val == 32'h0);
      if (arith) begin
        c = is_add ? (ur > 64'sh0FFFFFFFF) : (ur >= 0);
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end else begin
        c = sc;
      end
      f = {n, z, c, v};
    end
  endfunction

  task automatic do_reset();
    RESET = 1'b1;
    bus.START = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Drives one op; lat counts edges from the START sample edge until DONE is seen
  task automatic run_op(input logic [31:0] ir, input logic [31:0] rn, input logic [31:0] opd,
                        input logic sc, output int lat, output logic [31:0] res,
                        output logic [3:0] flg, output logic wr, output logic cin,
                        output logic [1:0] bsy);
    @(negedge CLK);
    bus.IR = ir; bus.RN = rn; bus.OPERAND = opd; bus.SHIFT_COUT = sc; bus.START = 1'b1;
    @(posedge CLK);
    lat = 1;
    @(negedge CLK);
    bus.START = 1'b0;
    bsy = 2'b00;
    while (!bus.DONE && lat < 10) begin
      bsy = {bsy[0], bus.BUSY};
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
    res = bus.RESULT; flg = bus.FLAGS; wr = bus.WRITE_RD; cin = bus.CIN_OUT;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    checks++;
    if (bus.RESULT !== 32'h0 || bus.FLAGS !== 4'b0000 || bus.WRITE_RD !== 1'b0 ||
        bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.CIN_OUT !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got res=%h flags=%b wr=%b busy=%b done=%b cin=%b, want 0/0000/0/0/0/0",
               bus.RESULT, bus.FLAGS, bus.WRITE_RD, bus.BUSY, bus.DONE, bus.CIN_OUT);
    end
  endtask

  task automatic test_adds_overflow();
    int lat; logic [31:0] res; logic [3:0] flg; logic wr, cin; logic [1:0] bsy;
    do_reset();
    run_op(32'hE09A102C, 32'h7FFFFFFF, 32'h00000001, 1'b0, lat, res, flg, wr, cin, bsy);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL adds_latency: got %0d want 3", lat); end
    checks++;
    if (bsy !== 2'b11) begin failures++; $display("FAIL adds_busy: got %b want 11", bsy); end
    checks++;
    if (res !== 32'h80000000 || flg !== 4'b1001 || wr !== 1'b1) begin
      failures++;
      $display("FAIL adds_result: got res=%h flags=%b wr=%b want 80000000/1001/1", res, flg, wr);
    end
  endtask

  task automatic test_cmp_equal();
    int lat; logic [31:0] res; logic [3:0] flg; logic wr, cin; logic [1:0] bsy;
    run_op(mk_ir(4'hE, 4'hA, 1'b1), 32'd5, 32'd5, 1'b0, lat, res, flg, wr, cin, bsy);
    checks++;
    if (res !== 32'h80000000 || flg !== 4'b0110 || wr !== 1'b0) begin
      failures++;
      $display("FAIL cmp_equal: got res=%h flags=%b wr=%b want 80000000/0110/0", res, flg, wr);
    end
  endtask

  task automatic test_cond_fail();
    int lat; logic [31:0] res; logic [3:0] flg; logic wr, cin; logic [1:0] bsy;
    do_reset();
    run_op(mk_ir(4'h0, 4'h4, 1'b1), 32'd1, 32'd1, 1'b0, lat, res, flg, wr, cin, bsy);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL cond_done: got latency %0d want 3", lat); end
    checks++;
`ifdef ALU_COND_EVAL_EN
    if (res !== 32'h0 || flg !== 4'b0000 || wr !== 1'b0) begin
      failures++;
      $display("FAIL cond_fail: got res=%h flags=%b wr=%b want 0/0000/0", res, flg, wr);
    end
`else
    if (res !== 32'd2 || flg !== 4'b0000 || wr !== 1'b1) begin
      failures++;
      $display("FAIL cond_ignored: got res=%h flags=%b wr=%b want 2/0000/1", res, flg, wr);
    end
`endif
  endtask

  task automatic test_movs_carry();
    int lat; logic [31:0] res; logic [3:0] flg; logic wr, cin; logic [1:0] bsy;
    do_reset();
    run_op(mk_ir(4'hE, 4'h4, 1'b1), 32'h7FFFFFFF, 32'h1, 1'b0, lat, res, flg, wr, cin, bsy);
    checks++;
    if (flg !== 4'b1001) begin failures++; $display("FAIL movs_preset: got %b want 1001", flg); end
    run_op(mk_ir(4'hE, 4'hD, 1'b1), 32'h12345678, 32'h0, 1'b1, lat, res, flg, wr, cin, bsy);
    checks++;
    if (res !== 32'h0 || flg !== 4'b0111 || cin !== 1'b1 || wr !== 1'b1) begin
      failures++;
      $display("FAIL movs_carry: got res=%h flags=%b cin=%b wr=%b want 0/0111/1/1", res, flg, cin, wr);
    end
  endtask

  task automatic test_adc_sbc_chain();
    int lat; logic [31:0] res; logic [3:0] flg; logic wr, cin; logic [1:0] bsy;
    do_reset();
    run_op(mk_ir(4'hE, 4'hD, 1'b1), 32'h0, 32'h1, 1'b1, lat, res, flg, wr, cin, bsy);
    run_op(mk_ir(4'hE, 4'h5, 1'b1), 32'hFFFFFFFF, 32'h0, 1'b0, lat, res, flg, wr, cin, bsy);
    checks++;
    if (res !== 32'h0 || flg !== 4'b0110) begin
      failures++;
      $display("FAIL adc_chain: got res=%h flags=%b want 0/0110", res, flg);
    end
    run_op(mk_ir(4'hE, 4'h6, 1'b1), 32'd3, 32'd1, 1'b0, lat, res, flg, wr, cin, bsy);
    checks++;
    if (res !== 32'd2 || flg !== 4'b0010) begin
      failures++;
      $display("FAIL sbc_chain: got res=%h flags=%b want 2/0010", res, flg);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat; int dones; logic [31:0] res; logic [3:0] flg; logic wr, cin; logic [1:0] bsy;
    do_reset();
    run_op(mk_ir(4'hE, 4'h4, 1'b1), 32'h7FFFFFFF, 32'h1, 1'b0, lat, res, flg, wr, cin, bsy);
    @(negedge CLK);
    bus.IR = mk_ir(4'hE, 4'h2, 1'b1); bus.RN = 32'd9; bus.OPERAND = 32'd4; bus.START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.START = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (bus.BUSY !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b want 1", bus.BUSY); end
    RESET = 1'b1;
    #1;
    checks++;
    if (bus.RESULT !== 32'h0 || bus.FLAGS !== 4'b0000 || bus.WRITE_RD !== 1'b0 ||
        bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got res=%h flags=%b wr=%b busy=%b done=%b want all zero",
               bus.RESULT, bus.FLAGS, bus.WRITE_RD, bus.BUSY, bus.DONE);
    end
    @(negedge CLK);
    RESET = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (bus.DONE) dones++;
    end
    checks++;
    if (dones !== 0) begin failures++; $display("FAIL mid_no_done: got %0d dones want 0", dones); end
  endtask

  task automatic test_start_held();
    int dones;
    do_reset();
    @(negedge CLK);
    bus.IR = mk_ir(4'hE, 4'h4, 1'b0); bus.RN = 32'd20; bus.OPERAND = 32'd22; bus.START = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (i == 3) bus.START = 1'b0;
      if (bus.DONE) dones++;
    end
    checks++;
    if (dones !== 1 || bus.RESULT !== 32'd42) begin
      failures++;
      $display("FAIL start_held: got dones=%0d res=%0d want 1/42", dones, bus.RESULT);
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] res; logic [3:0] flg; logic wr, cin; logic [1:0] bsy;
    logic [3:0] mf; logic [31:0] mr; logic mw;
    logic [31:0] ir, rn, opd; logic sc;
    logic [31:0] edges [6];
    edges[0] = 32'h0; edges[1] = 32'hFFFFFFFF; edges[2] = 32'h7FFFFFFF;
    edges[3] = 32'h80000000; edges[4] = 32'h1; edges[5] = 32'h80000001;
    do_reset();
    mf = 4'b0000; mr = 32'h0;
    for (int i = 0; i < 300; i++) begin
      ir  = {4'($urandom_range(0, 15)), 3'b000, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             20'($urandom)};
      rn  = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      opd = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 3) == 0) opd = rn;
      sc  = 1'($urandom_range(0, 1));
      run_op(ir, rn, opd, sc, lat, res, flg, wr, cin, bsy);
      model(ir, rn, opd, sc, mf, mr, mw);
      checks++;
      if (lat !== 3 || res !== mr || flg !== mf || wr !== mw || cin !== mf[1]) begin
        failures++;
        $display("FAIL random[%0d] ir=%h rn=%h op=%h sc=%b: got lat=%0d res=%h f=%b wr=%b cin=%b want 3/%h/%b/%b/%b",
                 i, ir, rn, opd, sc, lat, res, flg, wr, cin, mr, mf, mw, mf[1]);
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    bus.START = 1'b0; bus.IR = '0; bus.RN = '0; bus.OPERAND = '0; bus.SHIFT_COUT = 1'b0;
    test_reset();
    test_adds_overflow();
    test_cmp_equal();
    test_cond_fail();
    test_movs_carry();
    test_adc_sbc_chain();
    test_reset_mid_op();
    test_start_held();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
